// File: rtl/mmu_mem_req_queue.sv
// mmu_mem_req_queue
//
// Downstream stage of one MMU translation port. Each translated access is
// captured in an in-order queue. Non-faulting accesses are sent to the
// cache/bus over a valid/ready handshake, and their in-order responses are
// matched back to the queue. Faulting accesses never reach the cache; they
// complete at enqueue time and carry their exception. Results retire to the
// pipeline strictly in program order.
//
// Ports
//   clk, rstn         clock, synchronous active-low reset
//   flush             drop every entry; responses still owed are discarded
//   in_*              access from the MMU output register (valid, vaddr,
//                     optype, paddr, excp, memtype, wdata)
//   in_stall          queue full, MMU port must hold its output
//   req_*             request to cache/bus (valid/ready, paddr, uncached,
//                     op, wdata)
//   resp_valid/data   in-order response from cache/bus
//   out_*             head entry towards the pipeline (valid/ready, vaddr,
//                     data, excp)
module mmu_mem_req_queue #(
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [31:0]       in_vaddr,
    input  logic [1:0]        in_optype,
    input  logic [31:0]       in_paddr,
    input  logic [15:0]       in_excp,
    input  logic [1:0]        in_memtype,
    input  logic [DATA_W-1:0] in_wdata,
    output logic              in_stall,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [31:0]       req_paddr,
    output logic              req_uncached,
    output logic [1:0]        req_op,
    output logic [DATA_W-1:0] req_wdata,
    input  logic              resp_valid,
    input  logic [DATA_W-1:0] resp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_vaddr,
    output logic [DATA_W-1:0] out_data,
    output logic [15:0]       out_excp
);

    localparam logic [1:0] ST_EMPTY  = 2'd0;
    localparam logic [1:0] ST_PEND   = 2'd1;
    localparam logic [1:0] ST_ISSUED = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [1:0] OP_STORE    = 2'd2;
    localparam logic [1:0] MT_UNCACHED = 2'd0;

    // Per-entry control state (reset) and payload (no reset needed).
    logic [1:0]        state_q   [DEPTH];
    logic [1:0]        state_d   [DEPTH];
    logic [31:0]       vaddr_q   [DEPTH];
    logic [1:0]        optype_q  [DEPTH];
    logic [31:0]       paddr_q   [DEPTH];
    logic [15:0]       excp_q    [DEPTH];
    logic [1:0]        memtype_q [DEPTH];
    logic [DATA_W-1:0] wdata_q   [DEPTH];
    logic [DATA_W-1:0] data_q    [DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W:0]   tail_q, tail_d;
    logic [PTR_W:0]   issue_q, issue_d;
    logic [PTR_W:0]   resp_q, resp_d;
    logic [PTR_W:0]   head_q, head_d;
    logic [PTR_W+1:0] drop_cnt_q, drop_cnt_d;

    logic [PTR_W-1:0] tail_idx, issue_idx, resp_idx, head_idx, rsp_idx;
    logic             full, empty;
    logic             enq, req_fire, retire, rsp_wr;
    logic             issue_has_entry;
    logic [PTR_W:0]   rsp_ptr;
    logic             rsp_hit;
    logic [PTR_W+1:0] issued_cnt;

    assign tail_idx  = tail_q[PTR_W-1:0];
    assign issue_idx = issue_q[PTR_W-1:0];
    assign resp_idx  = resp_q[PTR_W-1:0];
    assign head_idx  = head_q[PTR_W-1:0];
    assign rsp_idx   = rsp_ptr[PTR_W-1:0];

    assign empty    = (tail_q == head_q);
    assign full     = (tail_q == {~head_q[PTR_W], head_q[PTR_W-1:0]});
    assign in_stall = full;

    assign enq = in_valid && !full && !flush;

    // Uncached requests wait until nothing is outstanding; stores wait until
    // they are the oldest entry so they are never sent speculatively.
    assign issue_has_entry = (issue_q != tail_q);
    assign req_valid = issue_has_entry
                     && (state_q[issue_idx] == ST_PEND)
                     && ((memtype_q[issue_idx] != MT_UNCACHED) || (issue_q == resp_q))
                     && ((optype_q[issue_idx] != OP_STORE) || (issue_q == head_q));
    assign req_paddr    = paddr_q[issue_idx];
    assign req_uncached = (memtype_q[issue_idx] == MT_UNCACHED);
    assign req_op       = optype_q[issue_idx];
    assign req_wdata    = wdata_q[issue_idx];
    assign req_fire     = req_valid && req_ready;

    assign out_valid = !empty && (state_q[head_idx] == ST_DONE);
    assign out_vaddr = vaddr_q[head_idx];
    assign out_data  = data_q[head_idx];
    assign out_excp  = excp_q[head_idx];
    assign retire    = out_valid && out_ready;

    // The resp pointer only skips one completed entry per cycle, so a response
    // can arrive while it still rests on an excepting entry (or one the head
    // has just retired). Scan forward to the oldest ISSUED entry so the data
    // always lands on the request it belongs to.
    always_comb begin
        rsp_ptr = resp_q;
        rsp_hit = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!rsp_hit && (rsp_ptr != issue_q)) begin
                if (state_q[rsp_ptr[PTR_W-1:0]] == ST_ISSUED) begin
                    rsp_hit = 1'b1;
                end else begin
                    rsp_ptr = rsp_ptr + 1'b1;
                end
            end
        end
    end

    always_comb begin
        issued_cnt = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (state_q[PTR_W'(k)] == ST_ISSUED) begin
                issued_cnt = issued_cnt + 1'b1;
            end
        end
    end

    assign rsp_wr = resp_valid && (drop_cnt_q == '0) && rsp_hit && !flush;

    always_comb begin
        state_d    = state_q;
        tail_d     = tail_q;
        issue_d    = issue_q;
        resp_d     = resp_q;
        head_d     = head_q;
        drop_cnt_d = drop_cnt_q;

        if (flush) begin
            // Every request already accepted by the cache (including one taken
            // this cycle) will still answer, so those answers must be dropped.
            // A response in this same cycle pays off one of them immediately.
            for (int k = 0; k < DEPTH; k++) begin
                state_d[PTR_W'(k)] = ST_EMPTY;
            end
            issue_d    = tail_q;
            resp_d     = tail_q;
            head_d     = tail_q;
            drop_cnt_d = drop_cnt_q + issued_cnt
                       + (PTR_W+2)'(req_fire) - (PTR_W+2)'(resp_valid);
        end else begin
            if (enq) begin
                state_d[tail_idx] = in_excp[15] ? ST_DONE : ST_PEND;
                tail_d            = tail_q + 1'b1;
            end

            if (req_fire) begin
                state_d[issue_idx] = ST_ISSUED;
                issue_d            = issue_q + 1'b1;
            end else if (issue_has_entry && (state_q[issue_idx] == ST_DONE)) begin
                issue_d = issue_q + 1'b1;
            end

            if (resp_valid && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - 1'b1;
            end

            if (rsp_wr) begin
                state_d[rsp_idx] = ST_DONE;
                resp_d           = rsp_ptr + 1'b1;
            end else if ((resp_q != issue_q) && (state_q[resp_idx] != ST_ISSUED)) begin
                resp_d = resp_q + 1'b1;
            end

            if (retire) begin
                state_d[head_idx] = ST_EMPTY;
                head_d            = head_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int k = 0; k < DEPTH; k++) begin
                state_q[PTR_W'(k)] <= ST_EMPTY;
            end
            tail_q     <= '0;
            issue_q    <= '0;
            resp_q     <= '0;
            head_q     <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            tail_q     <= tail_d;
            issue_q    <= issue_d;
            resp_q     <= resp_d;
            head_q     <= head_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Faulting accesses store zero data so out_data reads 0 for them.
    always_ff @(posedge clk) begin
        if (rstn && enq) begin
            vaddr_q[tail_idx]   <= in_vaddr;
            optype_q[tail_idx]  <= in_optype;
            paddr_q[tail_idx]   <= in_paddr;
            excp_q[tail_idx]    <= in_excp;
            memtype_q[tail_idx] <= in_memtype;
            wdata_q[tail_idx]   <= in_wdata;
            data_q[tail_idx]    <= in_excp[15] ? '0 : in_wdata;
        end
        if (rstn && rsp_wr) begin
            data_q[rsp_idx] <= resp_data;
        end
    end

    // A response with nothing outstanding and nothing left to drop means the
    // cache and this queue have lost agreement on the request stream.
    assert property (@(posedge clk) disable iff (!rstn)
        !(resp_valid && (drop_cnt_q == '0) && !rsp_hit));

endmodule
